// File: rtl/pq_pkg.sv
// Shared types for the priority-queue arbiter: FSM state encoding and command op codes.
package pq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } arb_state_t;

    localparam logic OP_INSERT = 1'b0;
    localparam logic OP_REMOVE = 1'b1;

endpackage

// File: rtl/pq_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping mod NREQ.
module pq_rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic            any_req
);

    always_comb begin
        int unsigned k;
        grant   = '0;
        any_req = 1'b0;
        k       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            k = (32'(ptr) + i) % NREQ;
            if (!any_req && req[PW'(k)]) begin
                grant[PW'(k)] = 1'b1;
                any_req       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pq_arbiter.sv
// Round-robin arbiter sharing one priority-queue command port between NREQ requesters.
// Optional watchdog on the PQ completion wait is enabled by defining PQ_ARB_TIMEOUT_EN.
module pq_arbiter
    import pq_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned KW        = 8,
    parameter int unsigned VW        = 8,
    parameter int unsigned TO_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ-1:0]    req_op,
    input  logic [NREQ*KW-1:0] req_key,
    input  logic [NREQ*VW-1:0] req_val,
    output logic [NREQ-1:0]    req_ready,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [KW-1:0]      rsp_key,
    output logic [VW-1:0]      rsp_val,
    output logic               pq_cmd_valid,
    output logic               pq_cmd_op,
    output logic [KW-1:0]      pq_key,
    output logic [VW-1:0]      pq_val,
    input  logic               pq_done,
    input  logic               pq_full,
    input  logic               pq_empty,
    input  logic [KW-1:0]      pq_rd_key,
    input  logic [VW-1:0]      pq_rd_val,
    output logic               arb_busy
);

    localparam int unsigned PW = $clog2(NREQ);

    if (NREQ < 2 || NREQ > 8 || TO_CYCLES == 0) begin : g_bad_params
        $error("pq_arbiter: NREQ must be 2..8 and TO_CYCLES nonzero");
    end

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   rr_q, rr_d;
    logic [PW-1:0]   idx_q, idx_d;
    logic            op_q, op_d;
    logic [KW-1:0]   key_q, key_d;
    logic [VW-1:0]   val_q, val_d;
    logic            err_q, err_d;
    logic [KW-1:0]   rkey_q, rkey_d;
    logic [VW-1:0]   rval_q, rval_d;

`ifdef PQ_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TO_CYCLES + 1);
    logic [CW-1:0]   wcnt_q, wcnt_d;
`endif

    logic [NREQ-1:0] grant;
    logic            any_req;
    logic [PW-1:0]   g_idx;
    logic            g_op;
    logic [KW-1:0]   g_key;
    logic [VW-1:0]   g_val;

    pq_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (req_valid),
        .ptr     (rr_q),
        .grant   (grant),
        .any_req (any_req)
    );

    // Encode the one-hot grant and mux out the winner's request fields.
    always_comb begin
        g_idx = '0;
        g_op  = 1'b0;
        g_key = '0;
        g_val = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                g_idx = PW'(i);
                g_op  = req_op[i];
                g_key = req_key[i*KW +: KW];
                g_val = req_val[i*VW +: VW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        idx_d   = idx_q;
        op_d    = op_q;
        key_d   = key_q;
        val_d   = val_q;
        err_d   = err_q;
        rkey_d  = rkey_q;
        rval_d  = rval_q;
`ifdef PQ_ARB_TIMEOUT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    idx_d   = g_idx;
                    op_d    = g_op;
                    key_d   = g_key;
                    val_d   = g_val;
                    err_d   = 1'b0;
                    rkey_d  = '0;
                    rval_d  = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if ((op_q == OP_INSERT && pq_full) || (op_q == OP_REMOVE && pq_empty)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
`ifdef PQ_ARB_TIMEOUT_EN
                wcnt_d  = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (pq_done) begin
                    if (op_q == OP_REMOVE) begin
                        rkey_d = pq_rd_key;
                        rval_d = pq_rd_val;
                    end
                    state_d = RESP;
                end
`ifdef PQ_ARB_TIMEOUT_EN
                else if (wcnt_q == CW'(TO_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    wcnt_d = wcnt_q + CW'(1);
                end
`endif
            end
            RESP: begin
                // Pointer advances past the served requester whether it succeeded or not.
                rr_d    = (idx_q == PW'(NREQ - 1)) ? '0 : idx_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            rr_q    <= '0;
            idx_q   <= '0;
            op_q    <= 1'b0;
            key_q   <= '0;
            val_q   <= '0;
            err_q   <= 1'b0;
            rkey_q  <= '0;
            rval_q  <= '0;
`ifdef PQ_ARB_TIMEOUT_EN
            wcnt_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            key_q   <= key_d;
            val_q   <= val_d;
            err_q   <= err_d;
            rkey_q  <= rkey_d;
            rval_q  <= rval_d;
`ifdef PQ_ARB_TIMEOUT_EN
            wcnt_q  <= wcnt_d;
`endif
        end
    end

    // All outputs except req_ready are straight decodes of the state and latch flops.
    assign arb_busy     = (state_q != IDLE);
    assign req_ready    = (state_q == IDLE) ? grant : '0;
    assign pq_cmd_valid = (state_q == ISSUE);
    assign pq_cmd_op    = (state_q == ISSUE) & op_q;
    assign pq_key       = (state_q == ISSUE) ? key_q : '0;
    assign pq_val       = (state_q == ISSUE) ? val_q : '0;
    assign rsp_valid    = (state_q == RESP) ? (NREQ'(1) << idx_q) : '0;
    assign rsp_err      = (state_q == RESP) & err_q;
    assign rsp_key      = (state_q == RESP) ? rkey_q : '0;
    assign rsp_val      = (state_q == RESP) ? rval_q : '0;

endmodule

// File: tb/tb_pq_arbiter.sv
// Directed self-checking bench for pq_arbiter (timeout case runs when PQ_ARB_TIMEOUT_EN is defined).
module tb_pq_arbiter;

`ifdef PQ_ARB_TIMEOUT_EN
    localparam int unsigned TB_TO = 16;
`else
    localparam int unsigned TB_TO = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_op, req_ready, rsp_valid;
    logic [31:0] req_key, req_val;
    logic        rsp_err, pq_cmd_valid, pq_cmd_op, pq_done, pq_full, pq_empty, arb_busy;
    logic [7:0]  rsp_key, rsp_val, pq_key, pq_val, pq_rd_key, pq_rd_val;

    int checks = 0;
    int errors = 0;

    pq_arbiter #(.NREQ(4), .KW(8), .VW(8), .TO_CYCLES(TB_TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_key      (req_key),
        .req_val      (req_val),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_key      (rsp_key),
        .rsp_val      (rsp_val),
        .pq_cmd_valid (pq_cmd_valid),
        .pq_cmd_op    (pq_cmd_op),
        .pq_key       (pq_key),
        .pq_val       (pq_val),
        .pq_done      (pq_done),
        .pq_full      (pq_full),
        .pq_empty     (pq_empty),
        .pq_rd_key    (pq_rd_key),
        .pq_rd_val    (pq_rd_val),
        .arb_busy     (arb_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ":ready"}, 32'(req_ready), 0);
        chk({tag, ":rsp_valid"}, 32'(rsp_valid), 0);
        chk({tag, ":rsp_err"}, 32'(rsp_err), 0);
        chk({tag, ":rsp_kv"}, {16'h0, rsp_key, rsp_val}, 0);
        chk({tag, ":cmd"}, {14'h0, pq_cmd_valid, pq_cmd_op, pq_key, pq_val}, 0);
        chk({tag, ":busy"}, 32'(arb_busy), 0);
    endtask

    // Full transaction starting in the IDLE cycle (inputs already driven), ending at posedge+1.
    task automatic txn(input string tag, input logic [3:0] gexp, input logic reject,
                       input logic exp_op, input logic [7:0] exp_key, input logic [7:0] exp_val,
                       input logic [7:0] rd_k, input logic [7:0] rd_v,
                       input logic [7:0] exp_rk, input logic [7:0] exp_rv, input logic drop);
        @(negedge clk);
        chk({tag, ":grant"}, 32'(req_ready), 32'(gexp));
        chk({tag, ":idle_busy"}, 32'(arb_busy), 0);
        go_edge();
        if (drop) req_valid = '0;
        @(negedge clk);
        chk({tag, ":check_ready"}, 32'(req_ready), 0);
        chk({tag, ":check_cmd"}, 32'(pq_cmd_valid), 0);
        chk({tag, ":check_busy"}, 32'(arb_busy), 1);
        go_edge();
        if (!reject) begin
            @(negedge clk);
            chk({tag, ":issue"}, {14'h0, pq_cmd_valid, pq_cmd_op, pq_key, pq_val},
                {14'h0, 1'b1, exp_op, exp_key, exp_val});
            go_edge();
            pq_done = 1'b1; pq_rd_key = rd_k; pq_rd_val = rd_v;
            @(negedge clk);
            chk({tag, ":wait_rsp"}, 32'(rsp_valid), 0);
            chk({tag, ":wait_cmd"}, 32'(pq_cmd_valid), 0);
            go_edge();
            pq_done = 1'b0; pq_rd_key = '0; pq_rd_val = '0;
        end
        @(negedge clk);
        chk({tag, ":rsp"}, {11'h0, rsp_valid, rsp_err, rsp_key, rsp_val},
            {11'h0, gexp, reject, exp_rk, exp_rv});
        chk({tag, ":resp_cmd"}, 32'(pq_cmd_valid), 0);
        go_edge();
        if (drop) begin
            @(negedge clk);
            chk_idle_outputs({tag, ":after"});
            go_edge();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; req_valid = '0; req_op = '0; req_key = '0; req_val = '0;
        pq_done = 1'b0; pq_full = 1'b0; pq_empty = 1'b1; pq_rd_key = '0; pq_rd_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("reset");
        go_edge();
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");
        go_edge();

        // Insert from requester 0 while the queue is empty but not full.
        req_valid = 4'b0001; req_op = 4'b0000; req_key = 32'h0000_0005; req_val = 32'h0000_00A1;
        txn("t2_insert", 4'b0001, 1'b0, 1'b0, 8'h05, 8'hA1, 8'hEE, 8'hEE, 8'h00, 8'h00, 1'b1);

        // Remove from requester 2 with an empty queue is rejected at T+2.
        req_valid = 4'b0100; req_op = 4'b0100; req_key = '0; req_val = '0;
        txn("t3_empty", 4'b0100, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        // Remove from requester 1 returns the head entry.
        pq_empty = 1'b0;
        req_valid = 4'b0010; req_op = 4'b0010;
        txn("t4_remove", 4'b0010, 1'b0, 1'b1, 8'h00, 8'h00, 8'h02, 8'h7F, 8'h02, 8'h7F, 1'b1);

        // Insert from requester 3 into a full queue is rejected; pointer wraps to 0.
        pq_full = 1'b1;
        req_valid = 4'b1000; req_op = 4'b0000; req_key = 32'h9900_0000; req_val = 32'h5500_0000;
        txn("full_insert", 4'b1000, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        pq_full = 1'b0;

        // Reset while waiting for completion; a late pq_done must not respond.
        req_valid = 4'b0010; req_op = 4'b0010;
        @(negedge clk);
        chk("t1_grant", 32'(req_ready), 32'b0010);
        go_edge();
        req_valid = '0;
        go_edge();
        go_edge();
        @(negedge clk);
        chk("t1_in_wait", 32'(arb_busy), 1);
        #1 rst = 1'b1;
        #1 chk_idle_outputs("t1_async");
        go_edge();
        chk_idle_outputs("t1_held");
        rst = 1'b0;
        go_edge();
        pq_done = 1'b1; pq_rd_key = 8'h33; pq_rd_val = 8'h44;
        @(negedge clk);
        chk_idle_outputs("t1_late_done");
        go_edge();
        pq_done = 1'b0; pq_rd_key = '0; pq_rd_val = '0;
        @(negedge clk);
        chk_idle_outputs("t1_after");
        go_edge();

        // All four requesters held valid: grants rotate 0,1,2,3 and wrap to 0.
        req_valid = 4'b1111; req_op = 4'b0000;
        req_key = 32'h4433_2211; req_val = 32'hD4C3_B2A1;
        txn("t5_g0", 4'b0001, 1'b0, 1'b0, 8'h11, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        txn("t5_g1", 4'b0010, 1'b0, 1'b0, 8'h22, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        txn("t5_g2", 4'b0100, 1'b0, 1'b0, 8'h33, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        txn("t5_g3", 4'b1000, 1'b0, 1'b0, 8'h44, 8'hD4, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
        txn("t5_wrap", 4'b0001, 1'b0, 1'b0, 8'h11, 8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

        // Requester 1 remove with no completion for a long time.
        req_valid = 4'b0010; req_op = 4'b0010; req_key = '0; req_val = '0;
        @(negedge clk);
        chk("wait_grant", 32'(req_ready), 32'b0010);
        go_edge();
        req_valid = '0;
        go_edge();
        @(negedge clk);
        chk("wait_issue", 32'(pq_cmd_valid), 1);
        go_edge();
`ifdef PQ_ARB_TIMEOUT_EN
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            go_edge();
            n++;
        end
        chk("t6_wait_cycles", 32'(n), 16);
        chk("t6_rsp", {11'h0, rsp_valid, rsp_err, rsp_key, rsp_val}, {11'h0, 4'b0010, 1'b1, 16'h0});
        go_edge();
        pq_done = 1'b1; pq_rd_key = 8'h09; pq_rd_val = 8'h3C;
        @(negedge clk);
        chk_idle_outputs("t6_late_done");
        go_edge();
        pq_done = 1'b0;
        @(negedge clk);
        chk_idle_outputs("t6_after");
`else
        n = 0;
        repeat (20) begin
            go_edge();
            if (rsp_valid != '0 || !arb_busy) n++;
        end
        chk("hold_no_rsp", 32'(n), 0);
        pq_done = 1'b1; pq_rd_key = 8'h09; pq_rd_val = 8'h3C;
        go_edge();
        pq_done = 1'b0; pq_rd_key = '0; pq_rd_val = '0;
        chk("hold_rsp", {11'h0, rsp_valid, rsp_err, rsp_key, rsp_val},
            {11'h0, 4'b0010, 1'b0, 8'h09, 8'h3C});
        go_edge();
        @(negedge clk);
        chk_idle_outputs("hold_after");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
